// File: rtl/fp_single_pkg.sv
// Shared definitions for the single-precision floating-point datapath.
//   - rounding-mode encodings as carried on the rm ports
//   - exponent limits and special-value bit patterns
//   - bit positions inside the 3-bit {overflow, underflow, inexact} flag vector
package fp_single_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,   // round to nearest, ties to even
        RM_RTZ = 2'd1,   // round toward zero
        RM_RUP = 2'd2,   // round toward +inf
        RM_RDN = 2'd3    // round toward -inf
    } rm_e;

    localparam int          EXP_BIAS      = 127;
    localparam logic [8:0]  EXP_MAX       = 9'd255;

    localparam logic [31:0] FP_POS_INF    = 32'h7F80_0000;
    localparam logic [30:0] FP_MAX_FINITE = 31'h7F7F_FFFF;

    localparam int FLAG_W  = 3;
    localparam int FLAG_NX = 0;   // inexact
    localparam int FLAG_UF = 1;   // underflow
    localparam int FLAG_OF = 2;   // overflow

endpackage

// File: rtl/round_incr_single.sv
// Rounding-increment decision for IEEE-754 single precision.
// Purely combinational; shared between the add/sub and multiply paths.
// Ports:
//   i_lsb      least significant kept fraction bit
//   i_guard    first discarded bit
//   i_sticky   OR of all remaining discarded bits
//   i_sign     sign of the value being rounded
//   i_rm       rounding mode (fp_single_pkg::rm_e encoding)
//   o_inc      add one ulp to the truncated significand
//   o_inexact  some discarded bit was non-zero
module round_incr_single
    import fp_single_pkg::*;
(
    input  logic       i_lsb,
    input  logic       i_guard,
    input  logic       i_sticky,
    input  logic       i_sign,
    input  logic [1:0] i_rm,
    output logic       o_inc,
    output logic       o_inexact
);

    logic w_inexact;

    assign w_inexact = i_guard | i_sticky;
    assign o_inexact = w_inexact;

    always_comb begin
        o_inc = 1'b0;
        case (i_rm)
            RM_RNE:  o_inc = i_guard & (i_sticky | i_lsb);  // exact tie goes to even lsb
            RM_RTZ:  o_inc = 1'b0;
            RM_RUP:  o_inc = w_inexact & ~i_sign;
            RM_RDN:  o_inc = w_inexact & i_sign;
            default: o_inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/round_pack_single.sv
// Final round-and-pack stage of the single-precision add/sub datapath.
// Two-stage valid/ready pipeline:
//   stage 1 rounds the normalized significand,
//   stage 2 resolves zero / underflow / carry-out / overflow and packs the word.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    upstream handshake
//   in_sign, in_exp        sign and biased exponent from the normalizer
//   in_exp_uf              exponent wrapped below zero during normalization
//   in_man                 [26] hidden, [25:3] fraction, [2] G, [1:0] R,S
//   in_rm                  rounding mode (RNE, RTZ, RUP, RDN)
//   out_valid / out_ready  downstream handshake
//   out_result             packed IEEE single
//   out_flags              {overflow, underflow, inexact}
module round_pack_single
    import fp_single_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_exp_uf,
    input  logic [MAN_W-1:0] in_man,
    input  logic [1:0]       in_rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [2:0]       out_flags
);

    // Significand including hidden bit, and its width after the rounding carry.
    localparam int SIG_W = MAN_W - 3;
    localparam int RND_W = SIG_W + 1;

    // Handshake
    logic w_s1_adv;
    logic w_s2_adv;

    // Stage 1 combinational
    logic             w_inc;
    logic             w_inexact;
    logic [RND_W-1:0] w_rounded;

    // Stage 1 registers
    logic             r_s1_valid;
    logic [RND_W-1:0] r_s1_round;
    logic [EXP_W-1:0] r_s1_exp;
    logic             r_s1_sign;
    logic [1:0]       r_s1_rm;
    logic             r_s1_inexact;
    logic             r_s1_uf;
    logic             r_s1_zero;

    // Stage 2 combinational
    logic [EXP_W:0]   w_exp9;
    logic [SIG_W-2:0] w_frac;
    logic [31:0]      w_result;
    logic [2:0]       w_flags;

    // Stage 2 registers
    logic             r_s2_valid;
    logic [31:0]      r_result;
    logic [2:0]       r_flags;

    assign w_s2_adv = ~r_s2_valid | out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv;

    assign out_valid  = r_s2_valid;
    assign out_result = r_result;
    assign out_flags  = r_flags;

    round_incr_single u_incr (
        .i_lsb     (in_man[3]),
        .i_guard   (in_man[2]),
        .i_sticky  (in_man[1] | in_man[0]),
        .i_sign    (in_sign),
        .i_rm      (in_rm),
        .o_inc     (w_inc),
        .o_inexact (w_inexact)
    );

    // Extra top bit catches the carry out of an all-ones significand.
    assign w_rounded = {1'b0, in_man[MAN_W-1:3]} + {{SIG_W{1'b0}}, w_inc};

    // ---- stage 1: round ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_adv && in_valid) begin
            r_s1_round   <= w_rounded;
            r_s1_exp     <= in_exp;
            r_s1_sign    <= in_sign;
            r_s1_rm      <= in_rm;
            r_s1_inexact <= w_inexact;
            r_s1_uf      <= in_exp_uf;
            r_s1_zero    <= ~in_man[MAN_W-1];
        end
    end

    // ---- stage 2: resolve specials and pack ----
    // On carry-out the significand is exactly 2.0, so shifting right by one
    // renormalizes it and leaves an all-zero fraction.
    assign w_exp9 = {1'b0, r_s1_exp} + {{EXP_W{1'b0}}, r_s1_round[RND_W-1]};
    assign w_frac = r_s1_round[RND_W-1] ? r_s1_round[SIG_W-1:1] : r_s1_round[SIG_W-2:0];

    always_comb begin
        w_result = 32'h0;
        w_flags  = 3'b000;
        if (r_s1_zero) begin
            // Exact zero takes its sign from the rounding direction.
            w_result          = {(r_s1_rm == RM_RDN), 31'h0};
            w_flags[FLAG_NX]  = r_s1_inexact;
        end else if (r_s1_uf || (r_s1_exp == '0)) begin
            w_result          = {r_s1_sign, 31'h0};
            w_flags[FLAG_UF]  = 1'b1;
            w_flags[FLAG_NX]  = 1'b1;
        end else if (w_exp9 >= EXP_MAX) begin
            w_flags[FLAG_OF]  = 1'b1;
            w_flags[FLAG_NX]  = 1'b1;
            // Saturate to infinity only when rounding heads away from zero.
            case (r_s1_rm)
                RM_RNE:  w_result = {r_s1_sign, FP_POS_INF[30:0]};
                RM_RTZ:  w_result = {r_s1_sign, FP_MAX_FINITE};
                RM_RUP:  w_result = r_s1_sign ? {1'b1, FP_MAX_FINITE} : FP_POS_INF;
                RM_RDN:  w_result = r_s1_sign ? {1'b1, FP_POS_INF[30:0]} : {1'b0, FP_MAX_FINITE};
                default: w_result = {r_s1_sign, FP_POS_INF[30:0]};
            endcase
        end else begin
            w_result          = {r_s1_sign, w_exp9[EXP_W-1:0], w_frac};
            w_flags[FLAG_NX]  = r_s1_inexact;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= 32'h0;
            r_flags    <= 3'b000;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_result;
                r_flags  <= w_flags;
            end
        end
    end

endmodule
